cu_channel_sequencer: RTL
=========================

Name: cu_channel_sequencer

Overview:
- Registered round-robin sequencer sitting directly upstream of the combinational control-unit decoder.
- Picks one of four requesting channels and drives the decoder's inputs:
  - channel select a/b;
  - opcode c/d/e/f;
  - phase o.
- Steps each grant through announce, service and release phases.
- Waits for the downstream service-done strobe, with a timeout backstop.

Parameters:
- ANN_CYCLES, 1, number of cycles the ANNOUNCE phase is held (legal values 1..7).
- TIMEOUT, 15, SERVICE cycles allowed before forced release (legal values 2..255).
- CNT_W, 8, width of the service timer and the served counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  per-channel service requests, bit k = channel k, level-sensitive.
- done  input  1  service-complete strobe from downstream decode; sampled only in SERVICE.
- clr_err  input  1  clears the sticky timeout_err.
- sel_a  output  1  channel index bit 0 (decoder input a).
- sel_b  output  1  channel index bit 1 (decoder input b).
- op  output  4  opcode {c,d,e,f} to decoder.
- phase_o  output  1  decoder phase input o.
- busy  output  1  high in every state except IDLE.
- timeout_err  output  1  sticky flag: a SERVICE phase expired without done.
- served_cnt  output  CNT_W  count of completed (non-timeout) services, wraps to 0.

Behaviour:
Interface:
- One clock; reset is synchronous and active-high.
- All outputs are registered; there is no combinational path from inputs to outputs.

Reset values (rst=1 at a rising edge):
- State IDLE, round-robin pointer ptr=0, sel_a=0, sel_b=0.
- op=4'b0100 (d=1, decoder quiescent), phase_o=0, busy=0.
- timeout_err=0, served_cnt=0, timer=0.
- Reset overrides every other input, including mid-SERVICE; no release cycle is emitted.

Channel selection:
- ch = first set bit of req searching ptr, ptr+1, ... modulo 4.

States and transitions:
- IDLE: op=0100, phase_o=0.
  - If req!=0: latch ch into {sel_b,sel_a} and go to ANNOUNCE.
  - If req=0: stay.
- ANNOUNCE: op=0001, phase_o=0. The decoder asserts the one-hot grant for sel in this phase.
  - Held for exactly ANN_CYCLES cycles, then go to SERVICE with timer=0.
- SERVICE: op=0011, phase_o=1; timer increments each cycle.
  - done=1: go to RELEASE, served_cnt+1.
  - Else, if timer==TIMEOUT-1: go to RELEASE and set timeout_err.
  - done on the same cycle as the timeout edge: done wins; count the service, no error.
- RELEASE: op=0100, phase_o=0, one cycle.
  - ptr <= sel+1 mod 4, then go to IDLE.
  - This guarantees at least two non-grant cycles between consecutive grants.

Latency:
- req first sampled high in IDLE at edge N:
  - ANNOUNCE outputs visible after edge N;
  - SERVICE after edge N+ANN_CYCLES.

Boundary conditions:
- sel is frozen from ANNOUNCE through RELEASE; req changes in that window are ignored.
- A channel whose req drops after selection is still fully served.
- done outside SERVICE is ignored.
- clr_err clears timeout_err. If set and clear happen in the same cycle, set wins.
- served_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- The timer saturates logically: it is reset to 0 on every SERVICE entry.

Test Plan:
- Reset with req=4'b1111 held, then release rst. Required: cycle after reset op=0100, sel=0; next edge ANNOUNCE op=0001, sel=0; then SERVICE op=0011, phase_o=1.
- Fairness: req=4'b1111 constant, done pulsed on the 2nd SERVICE cycle each time. Required: sel order 0,1,2,3,0 and served_cnt=5 after five grants.
- Wrap search: ptr=3 after serving channel 2, req=4'b0010. Required: sel=1 granted; next pointer 2.
- Timeout: TIMEOUT=15, req=4'b0100, done never asserted. Required: exactly 15 SERVICE cycles, then RELEASE; timeout_err=1; served_cnt unchanged. Pulsing clr_err then clears it.
- Done coincident with the last timeout cycle (timer=14). Required: timeout_err stays 0 and served_cnt increments. Separately, clr_err coincident with a new timeout leaves timeout_err=1.
- rst asserted on the 3rd SERVICE cycle. Required: next cycle op=0100, phase_o=0, busy=0, ptr=0, counters 0, no RELEASE cycle.

Source files
------------

// File: rtl/cu_channel_sequencer.sv
// cu_channel_sequencer: registered round-robin sequencer feeding the control-unit decoder
//   clk, rst        : clock, synchronous active-high reset
//   req[3:0]        : per-channel level requests
//   done            : service-complete strobe, honoured only in SERVICE
//   clr_err         : clears sticky timeout_err (a same-cycle set wins)
//   sel_a, sel_b    : granted channel index {sel_b,sel_a}
//   op[3:0]         : decoder opcode {c,d,e,f}
//   phase_o         : decoder phase input, high in SERVICE
//   busy            : high outside IDLE
//   timeout_err     : sticky, a SERVICE phase expired without done
//   served_cnt      : completed services, wraps silently
module cu_channel_sequencer #(
   parameter int ANN_CYCLES = 1,
   parameter int TIMEOUT    = 15,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req,
   input  logic             done,
   input  logic             clr_err,
   output logic             sel_a,
   output logic             sel_b,
   output logic [3:0]       op,
   output logic             phase_o,
   output logic             busy,
   output logic             timeout_err,
   output logic [CNT_W-1:0] served_cnt
);
   typedef enum logic [1:0] {IDLE, ANN, SVC, REL} state_t;
   state_t           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d, sel_q, sel_d, ch, idx;
   logic [2:0]       ann_q, ann_d;
   logic [CNT_W-1:0] timer_q, timer_d, served_q, served_d;
   logic             err_q, err_d, to_set;
   // descending scan so the request closest to ptr is the last one written
   always_comb begin
      ch  = ptr_q;
      idx = ptr_q;
      for (int k = 3; k >= 0; k--) begin
         idx = ptr_q + 2'(k);
         if (req[idx]) ch = idx;
      end
   end
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      sel_d    = sel_q;
      ann_d    = ann_q;
      timer_d  = timer_q;
      served_d = served_q;
      to_set   = 1'b0;
      case (state_q)
         IDLE: if (|req) begin
            sel_d   = ch;
            ann_d   = 3'd0;
            state_d = ANN;
         end
         ANN: if (ann_q == 3'(ANN_CYCLES - 1)) begin
            state_d = SVC;
            timer_d = '0;
         end else ann_d = ann_q + 3'd1;
         SVC: if (done) begin
            state_d  = REL;
            served_d = served_q + 1'b1;
         end else if (timer_q == CNT_W'(TIMEOUT - 1)) begin
            state_d = REL;
            to_set  = 1'b1;
         end else timer_d = timer_q + 1'b1;
         REL: begin
            ptr_d   = sel_q + 2'd1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      err_d = to_set | (err_q & ~clr_err);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= 2'd0;
         sel_q    <= 2'd0;
         ann_q    <= 3'd0;
         timer_q  <= '0;
         served_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         sel_q    <= sel_d;
         ann_q    <= ann_d;
         timer_q  <= timer_d;
         served_q <= served_d;
         err_q    <= err_d;
      end
   end
   assign sel_a       = sel_q[0];
   assign sel_b       = sel_q[1];
   assign op          = state_q == ANN ? 4'b0001 : state_q == SVC ? 4'b0011 : 4'b0100;
   assign phase_o     = state_q == SVC;
   assign busy        = state_q != IDLE;
   assign timeout_err = err_q;
   assign served_cnt  = served_q;
endmodule
